// File: rtl/branch_tag_if.sv
// Branch tag bus between ID/branch unit (master) and the tag controller (slave).
interface branch_tag_if #(
    parameter int unsigned TAG_WIDTH  = 2,
    parameter int unsigned ENTRIES    = 1 << TAG_WIDTH,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  alloc_req;
    logic                  alloc_ready;
    logic [TAG_WIDTH-1:0]  alloc_tag;
    logic [ENTRIES-1:0]    live_mask;
    logic                  resolve_valid;
    logic [TAG_WIDTH-1:0]  resolve_tag;
    logic                  resolve_mispredict;
    logic [ADDR_WIDTH-1:0] resolve_target;
    logic                  flush;
    logic [ENTRIES-1:0]    flush_mask;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  full;
    logic                  empty;

    modport master (
        output alloc_req, resolve_valid, resolve_tag, resolve_mispredict, resolve_target,
        input  alloc_ready, alloc_tag, live_mask, flush, flush_mask,
               redirect_valid, redirect_pc, full, empty
    );

    modport slave (
        input  alloc_req, resolve_valid, resolve_tag, resolve_mispredict, resolve_target,
        output alloc_ready, alloc_tag, live_mask, flush, flush_mask,
               redirect_valid, redirect_pc, full, empty
    );
endinterface

// File: rtl/branch_tag_ctrl.sv
// Branch tag allocator: age-ordered ring of in-flight branches with in-order retire
// and mispredict squash of younger tags followed by a one-cycle flush/redirect.
module branch_tag_ctrl #(
    parameter int unsigned TAG_WIDTH  = 2,
    parameter int unsigned ENTRIES    = 1 << TAG_WIDTH,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    branch_tag_if.slave bus
);
    localparam int unsigned TW = TAG_WIDTH;
    localparam int unsigned PW = TAG_WIDTH + 1;

    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [ENTRIES-1:0]    resolved_q, resolved_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic                  flush_q, flush_d;
    logic [ENTRIES-1:0]    flush_mask_q, flush_mask_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic [TW-1:0]         head_idx_c, tail_idx_c, t_off_c;
    logic                  full_c, empty_c, tag_live_c, mispred_c, alloc_fire_c, retire_c;
    logic [ENTRIES-1:0]    young_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q          <= '0;
            resolved_q       <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            flush_q          <= 1'b0;
            flush_mask_q     <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            valid_q          <= valid_d;
            resolved_q       <= resolved_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            flush_q          <= flush_d;
            flush_mask_q     <= flush_mask_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Next-state: resolve/squash, then retire at head, then allocate at tail
    always_comb begin
        head_idx_c   = head_q[TW-1:0];
        tail_idx_c   = tail_q[TW-1:0];
        full_c       = (head_q ^ tail_q) == {1'b1, {TW{1'b0}}};
        empty_c      = head_q == tail_q;
        tag_live_c   = valid_q[bus.resolve_tag];
        mispred_c    = bus.resolve_valid && bus.resolve_mispredict && tag_live_c;
        alloc_fire_c = bus.alloc_req && !full_c && !mispred_c;
        retire_c     = valid_q[head_idx_c] && resolved_q[head_idx_c];
        // Age of an entry is its distance from head; younger means larger distance
        t_off_c      = bus.resolve_tag - head_idx_c;
        young_c      = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            young_c[i] = valid_q[i] && (TW'(TW'(i) - head_idx_c) > t_off_c);
        end

        valid_d          = valid_q;
        resolved_d       = resolved_q;
        head_d           = head_q;
        tail_d           = tail_q;
        flush_d          = mispred_c;
        flush_mask_d     = mispred_c ? young_c : '0;
        redirect_valid_d = mispred_c;
        redirect_pc_d    = mispred_c ? bus.resolve_target : '0;

        if (bus.resolve_valid && tag_live_c) begin
            resolved_d[bus.resolve_tag] = 1'b1;
        end
        if (mispred_c) begin
            valid_d = valid_d & ~young_c;
            tail_d  = head_q + PW'(t_off_c) + PW'(1);
        end
        if (retire_c) begin
            valid_d[head_idx_c]    = 1'b0;
            resolved_d[head_idx_c] = 1'b0;
            head_d                 = head_q + PW'(1);
        end
        if (alloc_fire_c) begin
            valid_d[tail_idx_c]    = 1'b1;
            resolved_d[tail_idx_c] = 1'b0;
            tail_d                 = tail_q + PW'(1);
        end
    end

    assign bus.alloc_ready    = !full_c && !mispred_c;
    assign bus.alloc_tag      = tail_idx_c;
    assign bus.live_mask      = valid_q;
    assign bus.flush          = flush_q;
    assign bus.flush_mask     = flush_mask_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.full           = full_c;
    assign bus.empty          = empty_c;
endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Directed vector bench for branch_tag_ctrl: table of per-cycle inputs and expected outputs.
module tb_branch_tag_ctrl;
    logic clk;
    logic rst;

    branch_tag_if #(.TAG_WIDTH(2), .ENTRIES(4), .ADDR_WIDTH(32)) bus ();

    branch_tag_ctrl #(.TAG_WIDTH(2), .ENTRIES(4), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        areq;
        logic        rv;
        logic [1:0]  rtag;
        logic        rmis;
        logic [31:0] rtgt;
        logic        e_ready;
        logic [1:0]  e_tag;
        logic [3:0]  e_live;
        logic        e_flush;
        logic [3:0]  e_fmask;
        logic        e_rv;
        logic [31:0] e_pc;
        logic        e_full;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(string name, bit r, bit areq, bit rv, int rtag, bit rmis,
                                logic [31:0] rtgt, bit e_ready, int e_tag, logic [3:0] e_live,
                                bit e_flush, logic [3:0] e_fmask, bit e_rv, logic [31:0] e_pc,
                                bit e_full, bit e_empty);
        vec_t v;
        v.name = name; v.rst = r; v.areq = areq; v.rv = rv; v.rtag = 2'(rtag);
        v.rmis = rmis; v.rtgt = rtgt; v.e_ready = e_ready; v.e_tag = 2'(e_tag);
        v.e_live = e_live; v.e_flush = e_flush; v.e_fmask = e_fmask; v.e_rv = e_rv;
        v.e_pc = e_pc; v.e_full = e_full; v.e_empty = e_empty;
        return v;
    endfunction

    task automatic drive(bit r, bit areq, bit rv, logic [1:0] rtag, bit rmis, logic [31:0] rtgt);
        rst                    = r;
        bus.alloc_req          = areq;
        bus.resolve_valid      = rv;
        bus.resolve_tag        = rtag;
        bus.resolve_mispredict = rmis;
        bus.resolve_target     = rtgt;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    localparam logic [31:0] T0 = 32'h0040_0100;

    initial begin
        int cycles;
        n_vec = 0;
        n_bad = 0;

        //             name       rst areq rv tag mis target        rdy tag live    fl fmask   rv pc            full empty
        vecs.push_back(mk("reset",   0, 0, 0, 0, 0, 32'h0,          1, 0, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));
        vecs.push_back(mk("fill0",   1, 1, 0, 0, 0, 32'h0,          1, 0, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));
        vecs.push_back(mk("fill1",   1, 1, 0, 0, 0, 32'h0,          1, 1, 4'b0001, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("fill2",   1, 1, 0, 0, 0, 32'h0,          1, 2, 4'b0011, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("fill3",   1, 1, 0, 0, 0, 32'h0,          1, 3, 4'b0111, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("full5th", 1, 1, 0, 0, 0, 32'h0,          0, 0, 4'b1111, 0, 4'b0000, 0, 32'h0,          1, 0));
        vecs.push_back(mk("fullhld", 1, 0, 0, 0, 0, 32'h0,          0, 0, 4'b1111, 0, 4'b0000, 0, 32'h0,          1, 0));
        vecs.push_back(mk("mis1",    1, 1, 1, 1, 1, T0,             0, 0, 4'b1111, 0, 4'b0000, 0, 32'h0,          1, 0));
        vecs.push_back(mk("flush1",  1, 0, 0, 0, 0, 32'h0,          1, 2, 4'b0011, 1, 4'b1100, 1, T0,             0, 0));
        vecs.push_back(mk("realloc", 1, 1, 0, 0, 0, 32'h0,          1, 2, 4'b0011, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("res2",    1, 0, 1, 2, 0, 32'h0,          1, 3, 4'b0111, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("res0",    1, 0, 1, 0, 0, 32'h0,          1, 3, 4'b0111, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("ret0",    1, 0, 0, 0, 0, 32'h0,          1, 3, 4'b0111, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("ret1",    1, 0, 0, 0, 0, 32'h0,          1, 3, 4'b0110, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("ret2",    1, 0, 0, 0, 0, 32'h0,          1, 3, 4'b0100, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("drained", 1, 0, 0, 0, 0, 32'h0,          1, 3, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));
        vecs.push_back(mk("deadres", 1, 0, 1, 1, 1, T0,             1, 3, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));
        vecs.push_back(mk("deadchk", 1, 0, 0, 0, 0, 32'h0,          1, 3, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));
        vecs.push_back(mk("wrap3",   1, 1, 0, 0, 0, 32'h0,          1, 3, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));
        vecs.push_back(mk("wrap0",   1, 1, 0, 0, 0, 32'h0,          1, 0, 4'b1000, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("wrap1",   1, 1, 0, 0, 0, 32'h0,          1, 1, 4'b1001, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("misvsal", 1, 1, 1, 0, 1, 32'h0000_1234,  0, 2, 4'b1011, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("b2bmis",  1, 0, 1, 3, 1, 32'h0000_5678,  0, 1, 4'b1001, 1, 4'b0010, 1, 32'h0000_1234,  0, 0));
        vecs.push_back(mk("b2bfl",   1, 0, 0, 0, 0, 32'h0,          1, 0, 4'b1000, 1, 4'b0001, 1, 32'h0000_5678,  0, 0));
        vecs.push_back(mk("b2bdone", 1, 0, 0, 0, 0, 32'h0,          1, 0, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));
        vecs.push_back(mk("rsal",    1, 1, 0, 0, 0, 32'h0,          1, 0, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));
        vecs.push_back(mk("rsmis",   0, 0, 1, 0, 1, T0,             0, 1, 4'b0001, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("rsnofl",  1, 0, 0, 0, 0, 32'h0,          1, 0, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));
        vecs.push_back(mk("ylal",    1, 1, 0, 0, 0, 32'h0,          1, 0, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));
        vecs.push_back(mk("ylmis",   1, 0, 1, 0, 1, 32'hdead_beef,  0, 1, 4'b0001, 0, 4'b0000, 0, 32'h0,          0, 0));
        vecs.push_back(mk("ylfl",    1, 0, 0, 0, 0, 32'h0,          1, 1, 4'b0001, 1, 4'b0000, 1, 32'hdead_beef,  0, 0));
        vecs.push_back(mk("yldone",  1, 0, 0, 0, 0, 32'h0,          1, 1, 4'b0000, 0, 4'b0000, 0, 32'h0,          0, 1));

        drive(0, 0, 0, 2'd0, 0, 32'h0);
        repeat (2) @(posedge clk);

        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            @(negedge clk);
            drive(v.rst, v.areq, v.rv, v.rtag, v.rmis, v.rtgt);
            #1;
            n_vec++;
            if (bus.alloc_ready !== v.e_ready || bus.alloc_tag !== v.e_tag ||
                bus.live_mask !== v.e_live || bus.flush !== v.e_flush ||
                bus.flush_mask !== v.e_fmask || bus.redirect_valid !== v.e_rv ||
                bus.redirect_pc !== v.e_pc || bus.full !== v.e_full || bus.empty !== v.e_empty) begin
                n_bad++;
                $display("FAIL %s: got rdy=%b tag=%0d live=%b fl=%b fm=%b rv=%b pc=%h full=%b empty=%b; want rdy=%b tag=%0d live=%b fl=%b fm=%b rv=%b pc=%h full=%b empty=%b",
                         v.name, bus.alloc_ready, bus.alloc_tag, bus.live_mask, bus.flush,
                         bus.flush_mask, bus.redirect_valid, bus.redirect_pc, bus.full, bus.empty,
                         v.e_ready, v.e_tag, v.e_live, v.e_flush, v.e_fmask, v.e_rv, v.e_pc,
                         v.e_full, v.e_empty);
            end
        end

        // Out-of-order resolve: allocate 1,2,3, resolve 3, 1, 2; the last two retire over 2 cycles
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 1, 0, 2'd0, 0, 32'h0);
            #1;
            check($sformatf("ooo_tag%0d", k), 32'(bus.alloc_tag), 32'(k + 1));
        end
        @(negedge clk); drive(1, 0, 1, 2'd3, 0, 32'h0);
        @(negedge clk); drive(1, 0, 1, 2'd1, 0, 32'h0);
        @(negedge clk); drive(1, 0, 1, 2'd2, 0, 32'h0);
        #1;
        check("ooo_live_pre", 32'(bus.live_mask), 32'h0000_000e);
        @(negedge clk); drive(1, 0, 0, 2'd0, 0, 32'h0);
        #1;
        check("ooo_live_ret1", 32'(bus.live_mask), 32'h0000_000c);
        cycles = 0;
        while (bus.empty !== 1'b1 && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("ooo_drain_cycles", 32'(cycles), 32'd2);
        check("ooo_flush_idle", 32'(bus.flush), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
